// File: rtl/mem_stage.sv
// Memory-access pipeline stage: performs byte/half/word loads and stores as byte
// transfers on an 8-bit shared RAM bus. Optional alignment check via MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rd_in,
    input  logic [4:0]        rd_addr_in,
    input  logic [DATA_W-1:0] rd_val_in,
    input  logic [3:0]        inst_type_in,
    input  logic              load_in,
    input  logic              store_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_val_in,
    input  logic              mem_gnt_in,
    input  logic [7:0]        mem_din,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_a_out,
    output logic [7:0]        mem_dout,
    output logic              mem_wr_out,
    output logic              rd_out,
    output logic [4:0]        rd_addr_out,
    output logic [DATA_W-1:0] rd_val_out,
    output logic              stallreq_from_mem,
    output logic              misalign_out
);

    localparam logic [3:0] INST_LB  = 4'd1;
    localparam logic [3:0] INST_LH  = 4'd2;
    localparam logic [3:0] INST_LBU = 4'd4;
    localparam logic [3:0] INST_LHU = 4'd5;
    localparam logic [3:0] INST_SB  = 4'd6;
    localparam logic [3:0] INST_SH  = 4'd7;
    localparam int         LANES    = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_reg;
    logic [2:0]        cnt_reg;
    logic [DATA_W-1:0] data_buf_reg;
    logic              issued_reg;
    logic              skip_reg;

    logic              mem_op;
    logic [2:0]        size;
    logic              sext;
    logic              beat;
    logic              misaligned;
    logic [1:0]        cap_idx;
    logic [DATA_W-1:0] load_ext;
    logic [7:0]        val_lane [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign val_lane[gi] = mem_val_in[8*gi +: 8];
        end
    endgenerate

    assign mem_op  = load_in | store_in;
    assign beat    = (state_reg == XFER) && mem_gnt_in && (cnt_reg < size);
    assign cap_idx = cnt_reg[1:0] - 2'd1;

    always_comb begin
        size = 3'd4;
        sext = (inst_type_in == INST_LB) || (inst_type_in == INST_LH);
        case (inst_type_in)
            INST_LB, INST_LBU, INST_SB: size = 3'd1;
            INST_LH, INST_LHU, INST_SH: size = 3'd2;
            default:                    size = 3'd4;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((size == 3'd2) && mem_addr_in[0]) ||
                        ((size == 3'd4) && (mem_addr_in[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        load_ext = data_buf_reg;
        if (size == 3'd1)
            load_ext = {{(DATA_W-8){sext & data_buf_reg[7]}}, data_buf_reg[7:0]};
        else if (size == 3'd2)
            load_ext = {{(DATA_W-16){sext & data_buf_reg[15]}}, data_buf_reg[15:0]};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            data_buf_reg <= '0;
            issued_reg   <= 1'b0;
            skip_reg     <= 1'b0;
        end else begin
            // A read address driven now returns its byte next cycle.
            issued_reg <= beat && !store_in;
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        if (misaligned) begin
                            state_reg <= DONE;
                            skip_reg  <= 1'b1;
                        end else if (mem_gnt_in) begin
                            state_reg    <= XFER;
                            cnt_reg      <= 3'd0;
                            data_buf_reg <= '0;
                        end
                    end
                end
                XFER: begin
                    if (beat)
                        cnt_reg <= cnt_reg + 3'd1;
                    if (issued_reg)
                        data_buf_reg[{cap_idx, 3'b000} +: 8] <= mem_din;
                    if (store_in ? (beat && (cnt_reg == size - 3'd1)) : (cnt_reg == size))
                        state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                    skip_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_out       = 1'b0;
        mem_a_out         = '0;
        mem_dout          = 8'h00;
        mem_wr_out        = 1'b0;
        rd_out            = 1'b0;
        rd_addr_out       = '0;
        rd_val_out        = '0;
        stallreq_from_mem = 1'b0;
        misalign_out      = 1'b0;
        if (!rst_in) begin
            rd_addr_out = rd_addr_in;
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        stallreq_from_mem = 1'b1;
                        if (misaligned)
                            misalign_out = 1'b1;
                        else
                            mem_req_out = 1'b1;
                    end else begin
                        rd_out     = rd_in;
                        rd_val_out = rd_val_in;
                    end
                end
                XFER: begin
                    mem_req_out       = 1'b1;
                    stallreq_from_mem = mem_op;
                    if (beat) begin
                        mem_a_out = mem_addr_in + ADDR_W'(cnt_reg);
                        if (store_in) begin
                            mem_wr_out = 1'b1;
                            mem_dout   = val_lane[cnt_reg[1:0]];
                        end
                    end
                end
                DONE: begin
                    rd_out = rd_in & load_in & ~store_in & ~skip_reg;
                    if (load_in && !skip_reg)
                        rd_val_out = load_ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs, bus writes
// and stall lengths; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage;

    localparam logic [3:0] T_LB  = 4'd1;
    localparam logic [3:0] T_LH  = 4'd2;
    localparam logic [3:0] T_LW  = 4'd3;
    localparam logic [3:0] T_LBU = 4'd4;
    localparam logic [3:0] T_LHU = 4'd5;
    localparam logic [3:0] T_SH  = 4'd7;
    localparam logic [3:0] T_SW  = 4'd8;
    localparam logic [3:0] T_ALU = 4'd9;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rd_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] rd_val_in;
    logic [3:0]  inst_type_in;
    logic        load_in;
    logic        store_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_val_in;
    logic        mem_gnt_in;
    logic [7:0]  mem_din;
    logic        mem_req_out;
    logic [31:0] mem_a_out;
    logic [7:0]  mem_dout;
    logic        mem_wr_out;
    logic        rd_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_val_out;
    logic        stallreq_from_mem;
    logic        misalign_out;

    int errors = 0;
    int checks = 0;
    int run_len = 0;
    logic [36:0] wb_q[$];
    logic [39:0] wr_q[$];
    int          stall_q[$];

    logic [7:0] ram [0:8191];
    logic       ram_init;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in(clk), .rst_in(rst_in), .rd_in(rd_in), .rd_addr_in(rd_addr_in),
        .rd_val_in(rd_val_in), .inst_type_in(inst_type_in), .load_in(load_in),
        .store_in(store_in), .mem_addr_in(mem_addr_in), .mem_val_in(mem_val_in),
        .mem_gnt_in(mem_gnt_in), .mem_din(mem_din), .mem_req_out(mem_req_out),
        .mem_a_out(mem_a_out), .mem_dout(mem_dout), .mem_wr_out(mem_wr_out),
        .rd_out(rd_out), .rd_addr_out(rd_addr_out), .rd_val_out(rd_val_out),
        .stallreq_from_mem(stallreq_from_mem), .misalign_out(misalign_out)
    );

    // Byte RAM: read data valid one cycle after its address.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 8192; i++) ram[i] <= 8'h00;
            ram[13'h1004] <= 8'h78;
            ram[13'h1005] <= 8'h56;
            ram[13'h1006] <= 8'h34;
            ram[13'h1007] <= 8'h12;
            ram[13'h0020] <= 8'h80;
            ram[13'h0051] <= 8'hF0;
        end else if (mem_wr_out) begin
            ram[mem_a_out[12:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a_out[12:0]];
    end

    always @(negedge clk) begin
        logic [36:0] ewb;
        logic [39:0] ewr;
        int          est;
        if (stallreq_from_mem) begin
            run_len++;
        end else if (run_len > 0) begin
            checks++;
            if (stall_q.size() == 0) begin
                errors++;
                $display("FAIL stall_len: got %0d cycles, none expected", run_len);
            end else begin
                est = stall_q.pop_front();
                if (est != run_len) begin
                    errors++;
                    $display("FAIL stall_len: got %0d cycles expected %0d", run_len, est);
                end
            end
            run_len = 0;
        end
        if (mem_wr_out) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL bus_write: got %h<=%h, none expected", mem_a_out, mem_dout);
            end else begin
                ewr = wr_q.pop_front();
                if ({mem_a_out, mem_dout} !== ewr) begin
                    errors++;
                    $display("FAIL bus_write: got %h<=%h expected %h<=%h",
                             mem_a_out, mem_dout, ewr[39:8], ewr[7:0]);
                end
            end
        end
        if (rd_out && !stallreq_from_mem) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL writeback: got x%0d=%h, none expected", rd_addr_out, rd_val_out);
            end else begin
                ewb = wb_q.pop_front();
                if ({rd_addr_out, rd_val_out} !== ewb) begin
                    errors++;
                    $display("FAIL writeback: got x%0d=%h expected x%0d=%h",
                             rd_addr_out, rd_val_out, ewb[36:32], ewb[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rd_in = 1'b0; rd_addr_in = 5'd0; rd_val_in = 32'd0; inst_type_in = 4'd0;
        load_in = 1'b0; store_in = 1'b0; mem_addr_in = 32'd0; mem_val_in = 32'd0;
        mem_gnt_in = 1'b1;
    endtask

    // Called at posedge+1; holds the op until the DONE cycle (or a forced reset).
    task automatic run_op(input string name, input logic [3:0] ty, input logic ld,
                          input logic st, input logic rdi, input logic [4:0] rda,
                          input logic [31:0] rdv, input logic [31:0] addr,
                          input logic [31:0] sval, input logic [15:0] gmask,
                          input int rst_at, output logic first_req, output logic first_mis);
        int   cyc;
        logic fin;
        cyc = 0;
        fin = 1'b0;
        first_req = 1'b0;
        first_mis = 1'b0;
        inst_type_in = ty; load_in = ld; store_in = st; rd_in = rdi;
        rd_addr_in = rda; rd_val_in = rdv; mem_addr_in = addr; mem_val_in = sval;
        while (!fin) begin
            mem_gnt_in = (cyc < 16) ? gmask[cyc] : 1'b1;
            if (cyc == rst_at) rst_in = 1'b1;
            #1;
            if (cyc == 0) begin
                first_req = mem_req_out;
                first_mis = misalign_out;
            end
            if (rst_in || !stallreq_from_mem) begin
                fin = 1'b1;
            end else if (cyc >= 40) begin
                errors++;
                checks++;
                $display("FAIL timeout_%s: still stalled after %0d cycles", name, cyc);
                fin = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        @(posedge clk);
        #1;
        clear_inputs();
        rst_in = 1'b0;
        $display("op %-5s addr=%h cycles=%0d", name, addr, cyc);
    endtask

    initial begin
        logic r, m;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r, m;
        clear_inputs();
        ram_init = 1'b1;
        rst_in   = 1'b1;
        load_in = 1'b1; inst_type_in = T_LW; mem_addr_in = 32'h1004; rd_in = 1'b1;
        rd_val_in = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_stall", {31'd0, stallreq_from_mem}, 32'd0);
        chk("reset_req",   {31'd0, mem_req_out}, 32'd0);
        chk("reset_rd",    {31'd0, rd_out}, 32'd0);
        chk("reset_val",   rd_val_out, 32'd0);
        @(posedge clk);
        #1;
        clear_inputs();
        ram_init = 1'b0;
        rst_in   = 1'b0;
        @(posedge clk);
        #1;

        wb_q.push_back({5'd3, 32'h0000_0005});
        run_op("ADDI", T_ALU, 0, 0, 1, 5'd3, 32'd5, 32'd0, 32'd0, 16'hFFFF, -1, r, m);

        wb_q.push_back({5'd5, 32'h1234_5678}); stall_q.push_back(6);
        run_op("LW", T_LW, 1, 0, 1, 5'd5, 32'hDEADBEEF, 32'h1004, 32'd0, 16'hFFFF, -1, r, m);
        chk("lw_first_req", {31'd0, r}, 32'd1);

        wb_q.push_back({5'd6, 32'hFFFF_FF80}); stall_q.push_back(3);
        run_op("LB", T_LB, 1, 0, 1, 5'd6, 32'hDEADBEEF, 32'h20, 32'd0, 16'hFFFF, -1, r, m);

        wb_q.push_back({5'd7, 32'h0000_0080}); stall_q.push_back(4);
        run_op("LBU", T_LBU, 1, 0, 1, 5'd7, 32'hDEADBEEF, 32'h20, 32'd0, 16'hFFFE, -1, r, m);

        wr_q.push_back({32'h40, 8'h34}); wr_q.push_back({32'h41, 8'h12}); stall_q.push_back(3);
        run_op("SH", T_SH, 0, 1, 1, 5'd1, 32'hDEADBEEF, 32'h40, 32'hABCD1234, 16'hFFFF, -1, r, m);

        wb_q.push_back({5'd8, 32'hFFFF_F000}); stall_q.push_back(4);
        run_op("LH", T_LH, 1, 0, 1, 5'd8, 32'hDEADBEEF, 32'h50, 32'd0, 16'hFFFF, -1, r, m);

        wb_q.push_back({5'd9, 32'h0000_F000}); stall_q.push_back(4);
        run_op("LHU", T_LHU, 1, 0, 1, 5'd9, 32'hDEADBEEF, 32'h50, 32'd0, 16'hFFFF, -1, r, m);

        wb_q.push_back({5'd10, 32'h1234_5678}); stall_q.push_back(8);
        run_op("LWgnt", T_LW, 1, 0, 1, 5'd10, 32'hDEADBEEF, 32'h1004, 32'd0, 16'hFFE7, -1, r, m);

        wr_q.push_back({32'h100, 8'hAA}); wr_q.push_back({32'h101, 8'hBB}); stall_q.push_back(3);
        run_op("SWrst", T_SW, 0, 1, 0, 5'd0, 32'd0, 32'h100, 32'hDDCCBBAA, 16'hFFFF, 3, r, m);

        wb_q.push_back({5'd11, 32'h0000_BBAA}); stall_q.push_back(6);
        run_op("LW", T_LW, 1, 0, 1, 5'd11, 32'hDEADBEEF, 32'h100, 32'd0, 16'hFFFF, -1, r, m);

`ifdef MEM_ALIGN_CHECK_EN
        stall_q.push_back(1);
        run_op("LWmis", T_LW, 1, 0, 1, 5'd12, 32'hDEADBEEF, 32'h1002, 32'd0, 16'hFFFF, -1, r, m);
        chk("mis_flag", {31'd0, m}, 32'd1);
        chk("mis_req",  {31'd0, r}, 32'd0);
`else
        wb_q.push_back({5'd12, 32'h5678_0000}); stall_q.push_back(6);
        run_op("LWmis", T_LW, 1, 0, 1, 5'd12, 32'hDEADBEEF, 32'h1002, 32'd0, 16'hFFFF, -1, r, m);
        chk("mis_flag", {31'd0, m}, 32'd0);
        chk("mis_req",  {31'd0, r}, 32'd1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("ram_0x42",  {24'd0, ram[13'h042]}, 32'd0);
        chk("ram_0x102", {24'd0, ram[13'h102]}, 32'd0);
        chk("ram_0x103", {24'd0, ram[13'h103]}, 32'd0);
        chk("wb_left",    wb_q.size(), 32'd0);
        chk("wr_left",    wr_q.size(), 32'd0);
        chk("stall_left", stall_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
